// File: rtl/drysponge_f_driver_if.sv
// Bus between the F driver (master) and the F compression core (slave).
// Carries the en/done handshake plus the call operands and results.
interface drysponge_f_driver_if #(
    parameter int CWIDTH      = 320,
    parameter int IWIDTH      = 128,
    parameter int DS_WIDTH    = 4,
    parameter int RWIDTH      = 32,
    parameter int ROUND_COUNT = 10
);
    logic                   f_reset;
    logic                   f_en;
    logic [CWIDTH-1:0]      f_c;
    logic [IWIDTH-1:0]      f_i;
    logic [DS_WIDTH-1:0]    f_ds;
    logic [ROUND_COUNT-1:0] f_rounds;
    logic [CWIDTH-1:0]      f_cout;
    logic [RWIDTH-1:0]      f_rout;
    logic                   f_done;

    modport master (
        output f_reset, f_en, f_c, f_i, f_ds, f_rounds,
        input  f_cout, f_rout, f_done
    );

    modport slave (
        input  f_reset, f_en, f_c, f_i, f_ds, f_rounds,
        output f_cout, f_rout, f_done
    );
endinterface

// File: rtl/drysponge_f_driver.sv
// Sequencer for the F compression core: packs 32-bit words into blocks,
// pads short final blocks, builds the domain code, runs one F call per
// block while threading the chaining state, and streams each rout out.
module drysponge_f_driver #(
    parameter int CWIDTH      = 320,
    parameter int IWIDTH      = 128,
    parameter int DS_WIDTH    = 4,
    parameter int RWIDTH      = 32,
    parameter int ROUND_COUNT = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   empty_msg,
    input  logic [CWIDTH-1:0]      c_init,
    input  logic [1:0]             domain,
    input  logic [ROUND_COUNT-1:0] rounds_cfg,
    input  logic [31:0]            din,
    input  logic                   din_valid,
    input  logic                   din_last,
    output logic                   din_ready,
    drysponge_f_driver_if.master   fbus,
    output logic [RWIDTH-1:0]      rout_data,
    output logic                   rout_valid,
    output logic [CWIDTH-1:0]      c_final,
    output logic                   busy,
    output logic                   done
);
    localparam int WORDS = IWIDTH / 32;
    localparam int KW    = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [2:0] {IDLE, COLLECT, ARM, CALL, FINISH} state_t;

    state_t                 state_reg, state_next;
    logic [CWIDTH-1:0]      c_reg, c_next;
    logic [1:0]             domain_reg, domain_next;
    logic [ROUND_COUNT-1:0] rounds_reg, rounds_next;
    logic [IWIDTH-1:0]      block_reg, block_next;
    logic [KW-1:0]          k_reg, k_next;
    logic                   padded_reg, padded_next;
    logic                   final_reg, final_next;

    logic                   f_en_reg, f_en_next;
    logic [CWIDTH-1:0]      f_c_reg, f_c_next;
    logic [IWIDTH-1:0]      f_i_reg, f_i_next;
    logic [DS_WIDTH-1:0]    f_ds_reg, f_ds_next;
    logic [ROUND_COUNT-1:0] f_rounds_reg, f_rounds_next;
    logic [RWIDTH-1:0]      rout_data_reg, rout_data_next;
    logic                   rout_valid_reg, rout_valid_next;
    logic [CWIDTH-1:0]      c_final_reg, c_final_next;
    logic                   done_reg, done_next;
    logic                   din_ready_reg, din_ready_next;

    // Block contents after accepting din into slot k; when din_last closes a
    // short block, the slot right after it gets the 0x00000001 pad word.
    logic [IWIDTH-1:0]      collect_block;

    genvar gi;
    generate
        for (gi = 0; gi < WORDS; gi++) begin : g_slot
            assign collect_block[32*gi +: 32] =
                (KW'(gi) == k_reg)                  ? din :
                (din_last && (KW'(gi) > k_reg))     ?
                    ((KW'(gi) == k_reg + KW'(1)) ? 32'h0000_0001 : 32'h0) :
                block_reg[32*gi +: 32];
        end
    endgenerate

    // Next-state and next-output logic for the session sequencer.
    always_comb begin
        state_next      = state_reg;
        c_next          = c_reg;
        domain_next     = domain_reg;
        rounds_next     = rounds_reg;
        block_next      = block_reg;
        k_next          = k_reg;
        padded_next     = padded_reg;
        final_next      = final_reg;
        f_en_next       = f_en_reg;
        f_c_next        = f_c_reg;
        f_i_next        = f_i_reg;
        f_ds_next       = f_ds_reg;
        f_rounds_next   = f_rounds_reg;
        rout_data_next  = rout_data_reg;
        rout_valid_next = 1'b0;
        c_final_next    = c_final_reg;
        done_next       = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    c_next      = c_init;
                    domain_next = domain;
                    rounds_next = rounds_cfg;
                    k_next      = '0;
                    block_next  = '0;
                    padded_next = 1'b0;
                    final_next  = 1'b0;
                    if (empty_msg) begin
                        block_next  = {{(IWIDTH-32){1'b0}}, 32'h0000_0001};
                        padded_next = 1'b1;
                        final_next  = 1'b1;
                        state_next  = ARM;
                    end else begin
                        state_next  = COLLECT;
                    end
                end
            end
            COLLECT: begin
                if (din_valid && din_ready_reg) begin
                    block_next = collect_block;
                    if (k_reg == KW'(WORDS-1)) begin
                        // Full block: never padded, even when it is the last.
                        padded_next = 1'b0;
                        final_next  = din_last;
                        k_next      = '0;
                        state_next  = ARM;
                    end else if (din_last) begin
                        padded_next = 1'b1;
                        final_next  = 1'b1;
                        k_next      = k_reg + KW'(1);
                        state_next  = ARM;
                    end else begin
                        k_next      = k_reg + KW'(1);
                    end
                end
            end
            ARM: begin
                f_en_next  = 1'b1;
                state_next = CALL;
            end
            CALL: begin
                if (fbus.f_done) begin
                    c_next          = fbus.f_cout;
                    rout_data_next  = fbus.f_rout;
                    rout_valid_next = 1'b1;
                    f_en_next       = 1'b0;
                    block_next      = '0;
                    k_next          = '0;
                    state_next      = final_reg ? FINISH : COLLECT;
                end
            end
            FINISH: begin
                c_final_next = c_reg;
                done_next    = 1'b1;
                state_next   = IDLE;
            end
            default: state_next = IDLE;
        endcase

        // Call operands are loaded on entry to ARM and held through CALL.
        if (state_next == ARM) begin
            f_c_next      = c_next;
            f_i_next      = block_next;
            f_ds_next     = DS_WIDTH'({domain_next, final_next, padded_next});
            f_rounds_next = rounds_next;
        end

        din_ready_next = (state_next == COLLECT);
    end

    // State and registered-output update with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            c_reg          <= '0;
            domain_reg     <= '0;
            rounds_reg     <= '0;
            block_reg      <= '0;
            k_reg          <= '0;
            padded_reg     <= 1'b0;
            final_reg      <= 1'b0;
            f_en_reg       <= 1'b0;
            f_c_reg        <= '0;
            f_i_reg        <= '0;
            f_ds_reg       <= '0;
            f_rounds_reg   <= '0;
            rout_data_reg  <= '0;
            rout_valid_reg <= 1'b0;
            c_final_reg    <= '0;
            done_reg       <= 1'b0;
            din_ready_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            c_reg          <= c_next;
            domain_reg     <= domain_next;
            rounds_reg     <= rounds_next;
            block_reg      <= block_next;
            k_reg          <= k_next;
            padded_reg     <= padded_next;
            final_reg      <= final_next;
            f_en_reg       <= f_en_next;
            f_c_reg        <= f_c_next;
            f_i_reg        <= f_i_next;
            f_ds_reg       <= f_ds_next;
            f_rounds_reg   <= f_rounds_next;
            rout_data_reg  <= rout_data_next;
            rout_valid_reg <= rout_valid_next;
            c_final_reg    <= c_final_next;
            done_reg       <= done_next;
            din_ready_reg  <= din_ready_next;
        end
    end

    // F is held in reset during driver reset and for the ARM cycle before each call.
    assign fbus.f_reset  = reset | (state_reg == ARM);
    assign fbus.f_en     = f_en_reg;
    assign fbus.f_c      = f_c_reg;
    assign fbus.f_i      = f_i_reg;
    assign fbus.f_ds     = f_ds_reg;
    assign fbus.f_rounds = f_rounds_reg;

    assign din_ready  = din_ready_reg;
    assign rout_data  = rout_data_reg;
    assign rout_valid = rout_valid_reg;
    assign c_final    = c_final_reg;
    assign done       = done_reg;
    assign busy       = (state_reg != IDLE);
endmodule

// File: tb/tb_drysponge_f_driver.sv
// Scoreboard bench for drysponge_f_driver with a behavioural F core model.
module tb_drysponge_f_driver;
    localparam int CW = 320;
    localparam int IW = 128;
    localparam int DW = 4;
    localparam int RW = 32;
    localparam int RC = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          empty_msg;
    logic [CW-1:0] c_init;
    logic [1:0]    domain;
    logic [RC-1:0] rounds_cfg;
    logic [31:0]   din;
    logic          din_valid;
    logic          din_last;
    logic          din_ready;
    logic [RW-1:0] rout_data;
    logic          rout_valid;
    logic [CW-1:0] c_final;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    drysponge_f_driver_if #(.CWIDTH(CW), .IWIDTH(IW), .DS_WIDTH(DW),
                            .RWIDTH(RW), .ROUND_COUNT(RC)) fbus ();

    drysponge_f_driver #(.CWIDTH(CW), .IWIDTH(IW), .DS_WIDTH(DW),
                         .RWIDTH(RW), .ROUND_COUNT(RC)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .empty_msg  (empty_msg),
        .c_init     (c_init),
        .domain     (domain),
        .rounds_cfg (rounds_cfg),
        .din        (din),
        .din_valid  (din_valid),
        .din_last   (din_last),
        .din_ready  (din_ready),
        .fbus       (fbus),
        .rout_data  (rout_data),
        .rout_valid (rout_valid),
        .c_final    (c_final),
        .busy       (busy),
        .done       (done)
    );

    // Behavioural F: done 6 cycles after en rises, counters cleared by f_reset.
    int fcnt;
    always @(posedge clk) begin
        if (fbus.f_reset || !fbus.f_en) fcnt <= 0;
        else                            fcnt <= fcnt + 1;
    end
    assign fbus.f_done = fbus.f_en && !fbus.f_reset && (fcnt == 6);
    assign fbus.f_cout = fbus.f_c ^ {fbus.f_i, 192'h0};
    assign fbus.f_rout = fbus.f_i[31:0] ^ 32'hA5A5_A5A5;

    typedef struct {
        logic [CW-1:0] c;
        logic [IW-1:0] i;
        logic [DW-1:0] ds;
        logic [RC-1:0] r;
    } call_t;

    call_t         call_q[$];
    logic [RW-1:0] rout_q[$];
    logic [CW-1:0] cfin_q[$];

    int errors = 0;
    int checks = 0;
    int calls_seen = 0;
    int rout_seen = 0;
    int done_seen = 0;
    logic din_ready_seen = 1'b0;

    task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compares every DUT-presented call, rout and done against the queues.
    logic prev_en = 1'b0;
    logic prev_freset = 1'b1;
    always @(negedge clk) begin
        call_t e;
        if (reset) begin
            prev_en     = 1'b0;
            prev_freset = 1'b1;
        end else begin
            if (fbus.f_en && !prev_en) begin
                calls_seen++;
                check("f_reset_before_call", CW'(prev_freset), CW'(1));
                if (call_q.size() == 0) begin
                    check("unexpected_call", CW'(1), CW'(0));
                end else begin
                    e = call_q.pop_front();
                    check("call_f_c", fbus.f_c, e.c);
                    check("call_f_i", CW'(fbus.f_i), CW'(e.i));
                    check("call_f_ds", CW'(fbus.f_ds), CW'(e.ds));
                    check("call_f_rounds", CW'(fbus.f_rounds), CW'(e.r));
                end
            end
            if (rout_valid) begin
                rout_seen++;
                if (rout_q.size() == 0) check("unexpected_rout", CW'(1), CW'(0));
                else                    check("rout_data", CW'(rout_data), CW'(rout_q.pop_front()));
            end
            if (done) begin
                done_seen++;
                if (cfin_q.size() == 0) check("unexpected_done", CW'(1), CW'(0));
                else                    check("c_final", c_final, cfin_q.pop_front());
            end
            if (din_ready) din_ready_seen = 1'b1;
            prev_en     = fbus.f_en;
            prev_freset = fbus.f_reset;
        end
    end

    task automatic push_call(input logic [CW-1:0] c, input logic [IW-1:0] i,
                             input logic [DW-1:0] ds, input logic [RC-1:0] r);
        call_t e;
        e.c = c; e.i = i; e.ds = ds; e.r = r;
        call_q.push_back(e);
    endtask

    task automatic start_session(input logic [CW-1:0] c, input logic [1:0] d,
                                 input logic [RC-1:0] r, input logic em);
        @(negedge clk);
        start = 1'b1; empty_msg = em; c_init = c; domain = d; rounds_cfg = r;
        @(negedge clk);
        start = 1'b0; empty_msg = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input logic last);
        int n = 0;
        @(negedge clk);
        din = w; din_valid = 1'b1; din_last = last;
        while (!din_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!din_ready) check("din_ready_timeout", CW'(0), CW'(1));
        @(posedge clk);
        #1;
        din_valid = 1'b0; din_last = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        while (done_seen < target && n < 300) begin
            @(posedge clk);
            n++;
        end
        check("done_timeout", CW'(done_seen >= target), CW'(1));
        repeat (5) @(negedge clk);
        check("done_count", CW'(done_seen), CW'(target));
    endtask

    task automatic check_drained(input string name);
        check(name, CW'(call_q.size() + rout_q.size() + cfin_q.size()), CW'(0));
    endtask

    task automatic scenario_full(input int done_target);
        logic [IW-1:0] i1;
        i1 = 128'h44444444_33333333_22222222_11111111;
        push_call(320'h0, i1, 4'b0110, 10'd12);
        rout_q.push_back(32'hB4B4_B4B4);
        cfin_q.push_back({i1, 192'h0});
        start_session(320'h0, 2'd1, 10'd12, 1'b0);
        send_word(32'h11111111, 1'b0);
        send_word(32'h22222222, 1'b0);
        send_word(32'h33333333, 1'b0);
        send_word(32'h44444444, 1'b1);
        wait_done(done_target);
        check_drained("full_drained");
    endtask

    logic [IW-1:0] ia, ib;
    logic [CW-1:0] c0, c1;
    int base_calls, base_rout, base_done, n;

    initial begin
        reset = 1'b1; start = 1'b0; empty_msg = 1'b0; c_init = '0; domain = '0;
        rounds_cfg = '0; din = '0; din_valid = 1'b0; din_last = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_f_reset", CW'(fbus.f_reset), CW'(1));
        check("rst_f_en", CW'(fbus.f_en), CW'(0));
        check("rst_f_i", CW'(fbus.f_i), CW'(0));
        check("rst_f_ds", CW'(fbus.f_ds), CW'(0));
        check("rst_f_c", fbus.f_c, CW'(0));
        check("rst_f_rounds", CW'(fbus.f_rounds), CW'(0));
        check("rst_rout", CW'({rout_data, rout_valid}), CW'(0));
        check("rst_c_final", c_final, CW'(0));
        check("rst_done_busy", CW'({done, busy}), CW'(0));
        check("rst_din_ready", CW'(din_ready), CW'(0));
        reset = 1'b0;
        @(negedge clk);
        check("idle_f_reset", CW'(fbus.f_reset), CW'(0));

        // 1: full final block, no extra padding block
        base_calls = calls_seen;
        scenario_full(1);
        check("s1_calls", CW'(calls_seen - base_calls), CW'(1));

        // 2: partial block padded with 0x1
        c0 = 320'h1234;
        ia = 128'h00000001_CCCC0000_BBBB0000_AAAA0000;
        push_call(c0, ia, 4'b1011, 10'd9);
        rout_q.push_back(32'h0F0F_A5A5);
        cfin_q.push_back(c0 ^ {ia, 192'h0});
        base_calls = calls_seen;
        start_session(c0, 2'd2, 10'd9, 1'b0);
        send_word(32'hAAAA0000, 1'b0);
        send_word(32'hBBBB0000, 1'b0);
        send_word(32'hCCCC0000, 1'b1);
        wait_done(2);
        check("s2_calls", CW'(calls_seen - base_calls), CW'(1));
        check_drained("s2_drained");

        // 3: empty message
        c0 = 320'hFF;
        ia = 128'h1;
        push_call(c0, ia, 4'b0011, 10'd5);
        rout_q.push_back(32'hA5A5_A5A4);
        cfin_q.push_back(c0 ^ {ia, 192'h0});
        din_ready_seen = 1'b0;
        base_calls = calls_seen;
        start_session(c0, 2'd0, 10'd5, 1'b1);
        wait_done(3);
        check("s3_din_ready_never", CW'(din_ready_seen), CW'(0));
        check("s3_calls", CW'(calls_seen - base_calls), CW'(1));
        check_drained("s3_drained");

        // 4: two blocks, gapped input, chaining through c
        c0 = 320'hDEAD_BEEF;
        ia = 128'h0D0E0F10_090A0B0C_05060708_01020304;
        ib = 128'h00000000_00000001_15161718_11121314;
        c1 = c0 ^ {ia, 192'h0};
        push_call(c0, ia, 4'b1100, 10'd10);
        push_call(c1, ib, 4'b1111, 10'd10);
        rout_q.push_back(32'hA4A7_A6A1);
        rout_q.push_back(32'hB4B7_B6B1);
        cfin_q.push_back(c1 ^ {ib, 192'h0});
        base_rout = rout_seen;
        start_session(c0, 2'd3, 10'd10, 1'b0);
        repeat (3) @(negedge clk); send_word(32'h01020304, 1'b0);
        repeat (3) @(negedge clk); send_word(32'h05060708, 1'b0);
        repeat (3) @(negedge clk); send_word(32'h090A0B0C, 1'b0);
        repeat (3) @(negedge clk); send_word(32'h0D0E0F10, 1'b0);
        repeat (3) @(negedge clk); send_word(32'h11121314, 1'b0);
        repeat (3) @(negedge clk); send_word(32'h15161718, 1'b1);
        wait_done(4);
        check("s4_rout_pulses", CW'(rout_seen - base_rout), CW'(2));
        check_drained("s4_drained");

        // 5: reset during CALL abandons the session
        push_call(320'h0, 128'h44444444_33333333_22222222_11111111, 4'b0110, 10'd12);
        base_done = done_seen;
        start_session(320'h0, 2'd1, 10'd12, 1'b0);
        send_word(32'h11111111, 1'b0);
        send_word(32'h22222222, 1'b0);
        send_word(32'h33333333, 1'b0);
        send_word(32'h44444444, 1'b1);
        n = 0;
        while (!fbus.f_en && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("s5_call_started", CW'(fbus.f_en), CW'(1));
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        check("s5_f_reset_during", CW'(fbus.f_reset), CW'(1));
        @(posedge clk);
        #1;
        check("s5_f_en_after", CW'(fbus.f_en), CW'(0));
        check("s5_busy_after", CW'(busy), CW'(0));
        check("s5_f_reset_after", CW'(fbus.f_reset), CW'(1));
        @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        check("s5_no_done", CW'(done_seen - base_done), CW'(0));
        check_drained("s5_drained");
        scenario_full(5);

        // 6: start during COLLECT is ignored
        c0 = 320'h5555;
        ia = 128'hD4D4D4D4_C3C3C3C3_B2B2B2B2_A1A1A1A1;
        push_call(c0, ia, 4'b0110, 10'd7);
        rout_q.push_back(32'h0404_0404);
        cfin_q.push_back(c0 ^ {ia, 192'h0});
        start_session(c0, 2'd1, 10'd7, 1'b0);
        send_word(32'hA1A1A1A1, 1'b0);
        send_word(32'hB2B2B2B2, 1'b0);
        @(negedge clk);
        start = 1'b1; c_init = 320'h9999; domain = 2'd2; rounds_cfg = 10'd3;
        @(negedge clk);
        start = 1'b0;
        send_word(32'hC3C3C3C3, 1'b0);
        send_word(32'hD4D4D4D4, 1'b1);
        wait_done(6);
        check_drained("s6_drained");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/drysponge_f_driver.md
Name: drysponge_f_driver

Overview:
- Initiator/sequencer for the F compression core (Mix128 followed by G); F is the responder in an en/done handshake.
- Accepts a 32-bit word stream and packs it into IWIDTH-bit blocks.
- Applies word-level padding and builds the domain-separation code.
- Issues one F call per block, threads the chaining state c between calls, and streams each call's rout word out.

Parameters:
- CWIDTH, 320, chaining-state width.
- IWIDTH, 128, F input block width; must be a multiple of 32.
- DS_WIDTH, 4, domain-separation code width.
- RWIDTH, 32, F rout width.
- ROUND_COUNT, 10, width of the rounds field.
- WORDS, IWIDTH/32, words per block (derived; not overridable).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin session; sampled in IDLE only.
- empty_msg  in  1  with start: session carries zero words.
- c_init  in  CWIDTH  initial chaining state, latched on start.
- domain  in  2  domain type, latched on start.
- rounds_cfg  in  ROUND_COUNT  rounds value, latched on start.
- din  in  32  data word.
- din_valid  in  1  din qualifier.
- din_last  in  1  marks the final word of the session.
- din_ready  out  1  driver accepts din.
- f_reset  out  1  to F reset.
- f_en  out  1  to F en.
- f_c  out  CWIDTH  to F c.
- f_i  out  IWIDTH  to F i.
- f_ds  out  DS_WIDTH  to F ds.
- f_rounds  out  ROUND_COUNT  to F rounds.
- f_cout  in  CWIDTH  from F cout.
- f_rout  in  RWIDTH  from F rout.
- f_done  in  1  from F done.
- rout_data  out  RWIDTH  captured rout.
- rout_valid  out  1  one-cycle pulse per completed F call.
- c_final  out  CWIDTH  chaining state after the final call.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse at session end.

Behaviour:
Reset:
- Synchronous, active-high; forces IDLE.
- Registered outputs go to: f_en=0, f_i=0, f_ds=0, f_c=0, f_rounds=0, rout_data=0, rout_valid=0, c_final=0, done=0, din_ready=0.
- f_reset = reset OR (state==ARM), so f_reset=1 while reset is high.
- Reset mid-call abandons the session; no done pulse.

FSM states: IDLE, COLLECT, ARM, CALL, FINISH.

IDLE:
- On start: latch c_init→c_reg, domain, rounds_cfg; clear the word counter.
- If empty_msg=1: build block = word0 0x00000001, remaining words 0; padded=1, final=1; go to ARM.
- If empty_msg=0: go to COLLECT.
- start outside IDLE is ignored.

COLLECT:
- din_ready=1.
- Each accepted word (din_valid & din_ready) is written to slot k, occupying bits [32k+31:32k]; k increments.
- Accepted word is the last slot (k=WORDS-1):
  - din_last=0: padded=0, final=0.
  - din_last=1: padded=0, final=1.
  - Either way, go to ARM.
- Accepted word has din_last=1 and k<WORDS-1:
  - Slot k+1 = 0x00000001; higher slots = 0.
  - padded=1, final=1; go to ARM.
- din_valid=0 holds the state.

ARM (1 cycle):
- f_reset=1 to clear F's internal counters.
- f_en=0, din_ready=0.
- Present f_c=c_reg, f_i=block, f_rounds=latched rounds.
- f_ds = {domain[1:0], final, padded}.

CALL:
- f_en=1; f_c, f_i, f_ds, f_rounds held stable.
- On the cycle f_done=1:
  - c_reg←f_cout, rout_data←f_rout; rout_valid=1 on the next cycle.
  - f_en deasserts on the next cycle.
  - Clear block and k.
  - final=0: go to COLLECT. final=1: go to FINISH.
- No timeout.

FINISH (1 cycle):
- c_final←c_reg; done=1; go to IDLE.
- c_final holds until the next start or reset.

Additional rules:
- Calls are back-to-back separated by at least ARM, so f_en is low for at least 1 cycle between calls.
- Latency from the last word accepted to done = 1 (ARM) + F latency + 2.
- A full final block is never followed by an extra padding block.

Test Plan:
Behavioural F model: f_done asserts 6 cycles after f_en rises; f_cout = f_c ^ {f_i, 192'h0}; f_rout = f_i[31:0] ^ 32'hA5A5A5A5.

1. Full block: c_init=0, domain=1, words 11111111, 22222222, 33333333, 44444444 (last on 4th).
   -> f_i=0x44444444_33333333_22222222_11111111, f_ds=4'b0110, one rout_valid with rout_data 0xB4B4B4B4, done once, c_final[319:192]=f_i.
2. Partial block: words AAAA0000, BBBB0000, CCCC0000 (last on 3rd), domain=2.
   -> f_i word3=0x00000001, f_ds=4'b1011, exactly one F call.
3. Empty message: start with empty_msg=1, domain=0.
   -> f_i=0x1, f_ds=4'b0011, din_ready never asserted, done after a single call.
4. Two blocks with din_valid gaps of 3 cycles, last on word 6.
   -> first call f_ds final=0 padded=0; second call c input equals first f_cout, word2=0x1, f_ds final=1 padded=1; two rout_valid pulses; f_reset pulses before each call.
5. Reset asserted for 1 cycle mid-CALL.
   -> next cycle f_en=0, busy=0, f_reset=1, no done pulse; a fresh session afterwards behaves as scenario 1.
6. start pulsed while in COLLECT.
   -> ignored; latched c_init/domain unchanged; session completes with the original values.
